// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit counters; define BTB_BYPASS_EN to forward
// a same-cycle update to a matching lookup.
module branch_target_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_fetch,
    input  logic        valid_rf_read,
    input  logic        valid_execute,
    input  logic [15:0] current_pc,
    input  logic        is_pc_jump,
    input  logic        jump,
    input  logic [15:0] target_pc,
    output logic        prediction,
    output logic [15:0] prediction_pc
);

    localparam int IW = $clog2(ENTRIES);
    localparam int TW = 15 - IW;

    logic          v_q   [ENTRIES];
    logic [TW-1:0] tag_q [ENTRIES];
    logic [15:0]   tgt_q [ENTRIES];
    logic [1:0]    ctr_q [ENTRIES];

    logic [15:0]   pc_rf;
    logic [15:0]   pc_ex;
    logic          jmp_ex;

    logic [IW-1:0] lk_idx;
    logic [TW-1:0] lk_tag;
    logic [IW-1:0] upd_idx;
    logic [TW-1:0] upd_tag;
    logic          upd_en;
    logic          upd_hit;
    logic [1:0]    new_ctr;
    logic [15:0]   new_tgt;
    logic          lk_hit;
    logic [1:0]    lk_ctr;
    logic [15:0]   lk_tgt;
    logic          unused_lsb;

    // Bit 0 is always zero for halfword-aligned PCs
    assign unused_lsb = current_pc[0] ^ pc_ex[0];

    assign lk_idx  = current_pc[IW:1];
    assign lk_tag  = current_pc[15:IW+1];
    assign upd_idx = pc_ex[IW:1];
    assign upd_tag = pc_ex[15:IW+1];
    assign upd_en  = valid_execute && jmp_ex;
    assign upd_hit = v_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_comb begin
        new_ctr = ctr_q[upd_idx];
        new_tgt = tgt_q[upd_idx];
        if (!upd_hit) begin
            new_ctr = jump ? 2'b10 : 2'b01;
            new_tgt = target_pc;
        end else if (jump) begin
            new_ctr = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
            new_tgt = target_pc;
        end else begin
            new_ctr = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
        end
    end

    always_comb begin
        lk_hit = v_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_ctr = ctr_q[lk_idx];
        lk_tgt = tgt_q[lk_idx];
`ifdef BTB_BYPASS_EN
        if (upd_en && (upd_idx == lk_idx) && (upd_tag == lk_tag)) begin
            lk_hit = 1'b1;
            lk_ctr = new_ctr;
            lk_tgt = new_tgt;
        end
`else
`endif
    end

    assign prediction    = lk_hit && lk_ctr[1];
    assign prediction_pc = prediction ? lk_tgt : current_pc + 16'd2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_rf  <= '0;
            pc_ex  <= '0;
            jmp_ex <= 1'b0;
        end else begin
            if (valid_fetch) begin
                pc_rf <= current_pc;
            end
            if (valid_rf_read) begin
                pc_ex  <= pc_rf;
                jmp_ex <= is_pc_jump;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                v_q[i]   <= 1'b0;
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'b01;
            end
        end else if (upd_en) begin
            v_q[upd_idx]   <= 1'b1;
            tag_q[upd_idx] <= upd_tag;
            tgt_q[upd_idx] <= new_tgt;
            ctr_q[upd_idx] <= new_ctr;
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor (ENTRIES=16: index pc[4:1],
// tag pc[15:5]); 0x0040/0x0060/0x0080 alias to index 0.
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_fetch;
    logic        valid_rf_read;
    logic        valid_execute;
    logic [15:0] current_pc;
    logic        is_pc_jump;
    logic        jump;
    logic [15:0] target_pc;
    logic        prediction;
    logic [15:0] prediction_pc;

    int checks = 0;
    int errors = 0;

    branch_target_predictor #(.ENTRIES(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .valid_fetch   (valid_fetch),
        .valid_rf_read (valid_rf_read),
        .valid_execute (valid_execute),
        .current_pc    (current_pc),
        .is_pc_jump    (is_pc_jump),
        .jump          (jump),
        .target_pc     (target_pc),
        .prediction    (prediction),
        .prediction_pc (prediction_pc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [15:0] pc,
                        input logic exp_p, input logic [15:0] exp_pc);
        current_pc = pc;
        @(negedge clk);
        chk({tag, ".pred"}, {15'd0, prediction}, {15'd0, exp_p});
        chk({tag, ".ppc"}, prediction_pc, exp_pc);
    endtask

    // Walk one branch through fetch, rf_read and execute
    task automatic resolve(input logic [15:0] pc, input logic j,
                           input logic [15:0] tgt);
        valid_fetch   = 1'b1;
        current_pc    = pc;
        step();
        valid_fetch   = 1'b0;
        valid_rf_read = 1'b1;
        is_pc_jump    = 1'b1;
        step();
        valid_rf_read = 1'b0;
        is_pc_jump    = 1'b0;
        valid_execute = 1'b1;
        jump          = j;
        target_pc     = tgt;
        step();
        valid_execute = 1'b0;
        jump          = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        valid_fetch   = 1'b0;
        valid_rf_read = 1'b0;
        valid_execute = 1'b0;
        is_pc_jump    = 1'b0;
        jump          = 1'b0;
        target_pc     = 16'h0000;
        current_pc    = 16'h0040;
        #3;
        chk("rst_in.pred", {15'd0, prediction}, 16'd0);
        chk("rst_in.ppc", prediction_pc, 16'h0042);
        step();
        reset = 1'b1;
        look("rst_out", 16'h0040, 1'b0, 16'h0042);

        // train taken: miss -> counter 10
        resolve(16'h0040, 1'b1, 16'h0100);
        look("taken1", 16'h0040, 1'b1, 16'h0100);
        resolve(16'h0040, 1'b0, 16'h1234);
        look("nt_01", 16'h0040, 1'b0, 16'h0042);
        resolve(16'h0040, 1'b0, 16'h1234);
        look("nt_00", 16'h0040, 1'b0, 16'h0042);
        resolve(16'h0040, 1'b0, 16'h1234);
        look("nt_sat", 16'h0040, 1'b0, 16'h0042);
        resolve(16'h0040, 1'b1, 16'h0100);
        look("t_01", 16'h0040, 1'b0, 16'h0042);
        resolve(16'h0040, 1'b1, 16'h0100);
        look("t_10", 16'h0040, 1'b1, 16'h0100);
        resolve(16'h0040, 1'b1, 16'h0100);
        resolve(16'h0040, 1'b1, 16'h0100);
        // saturated at 11: one not-taken keeps taken and old target
        resolve(16'h0040, 1'b0, 16'h1234);
        look("sat_11", 16'h0040, 1'b1, 16'h0100);
        resolve(16'h0040, 1'b0, 16'h1234);
        look("back_01", 16'h0040, 1'b0, 16'h0042);
        resolve(16'h0040, 1'b1, 16'h0100);
        look("re_10", 16'h0040, 1'b1, 16'h0100);

        // aliasing at index 0
        look("alias_miss", 16'h0060, 1'b0, 16'h0062);
        resolve(16'h0060, 1'b1, 16'h0200);
        look("alias_new", 16'h0060, 1'b1, 16'h0200);
        look("alias_old", 16'h0040, 1'b0, 16'h0042);
        // miss with not-taken allocates at 01
        resolve(16'h0080, 1'b0, 16'h0300);
        look("alloc_01", 16'h0080, 1'b0, 16'h0082);
        look("alloc_evict", 16'h0060, 1'b0, 16'h0062);
        resolve(16'h0080, 1'b1, 16'h0300);
        look("alloc_10", 16'h0080, 1'b1, 16'h0300);

        // non-jump in execute with rf_read stalled
        valid_fetch   = 1'b1;
        current_pc    = 16'h0044;
        step();
        valid_rf_read = 1'b1;
        is_pc_jump    = 1'b0;
        step();
        valid_rf_read = 1'b0;
        current_pc    = 16'h0048;
        valid_execute = 1'b1;
        jump          = 1'b1;
        target_pc     = 16'h0500;
        is_pc_jump    = 1'b1;
        step();
        is_pc_jump    = 1'b0;
        step();
        is_pc_jump    = 1'b1;
        step();
        valid_fetch   = 1'b0;
        valid_execute = 1'b0;
        jump          = 1'b0;
        is_pc_jump    = 1'b0;
        look("stall_44", 16'h0044, 1'b0, 16'h0046);
        look("stall_48", 16'h0048, 1'b0, 16'h004a);

        // same-cycle update and lookup at 0x0040
        resolve(16'h0040, 1'b1, 16'h0100);
        look("pre_same", 16'h0040, 1'b1, 16'h0100);
        valid_fetch   = 1'b1;
        step();
        valid_fetch   = 1'b0;
        valid_rf_read = 1'b1;
        is_pc_jump    = 1'b1;
        step();
        valid_rf_read = 1'b0;
        is_pc_jump    = 1'b0;
        valid_execute = 1'b1;
        jump          = 1'b0;
        target_pc     = 16'h0700;
`ifdef BTB_BYPASS_EN
        look("same_cyc", 16'h0040, 1'b0, 16'h0042);
`else
        look("same_cyc", 16'h0040, 1'b1, 16'h0100);
`endif
        step();
        valid_execute = 1'b0;
        look("after_same", 16'h0040, 1'b0, 16'h0042);
        look("wrap", 16'hFFFE, 1'b0, 16'h0000);

        // reset during a pending update discards it
        resolve(16'h0040, 1'b1, 16'h0100);
        look("pre_rst", 16'h0040, 1'b1, 16'h0100);
        valid_fetch   = 1'b1;
        current_pc    = 16'h0050;
        step();
        valid_fetch   = 1'b0;
        valid_rf_read = 1'b1;
        is_pc_jump    = 1'b1;
        step();
        valid_rf_read = 1'b0;
        is_pc_jump    = 1'b0;
        valid_execute = 1'b1;
        jump          = 1'b1;
        target_pc     = 16'h0600;
        #2;
        reset = 1'b0;
        step();
        valid_execute = 1'b0;
        jump          = 1'b0;
        reset = 1'b1;
        look("rst_drop", 16'h0050, 1'b0, 16'h0052);
        look("rst_clr", 16'h0040, 1'b0, 16'h0042);
        // cleared jmp_ex blocks any update from execute
        valid_execute = 1'b1;
        jump          = 1'b1;
        target_pc     = 16'h0600;
        step();
        valid_execute = 1'b0;
        jump          = 1'b0;
        look("rst_jmp", 16'h0050, 1'b0, 16'h0052);
        look("rst_pc0", 16'h0000, 1'b0, 16'h0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
